noc_traffic_injector: RTL and testbench
=======================================

// Module: noc_traffic_injector
// PURPOSE
//  Programmable packet source bound to one mesh node's receive port (Noc_X_Y_receive_*).
//  Upstream stage of the router: produces header/body/tail flits and implements valid/ready backpressure.
//  Used in NoC simulation tops, with one instance per node, in place of empty nodes.
// PARAMETERS
//  DATA_W   32  flit width (must equal `Noc_Data_Width)
//  COORD_W  4   width of one X or Y coordinate
//  SRC_X    0   this node's X coordinate, written into every header
//  SRC_Y    0   this node's Y coordinate, written into every header
//  LEN_W    8   width of the packet-length field, counted in flits
// PORTS
//  noc_clk        in   1        single clock
//  noc_rst        in   1        asynchronous, active-high reset
//  cfg_start      in   1        1-cycle pulse; latches cfg_* and starts a burst; ignored while busy
//  cfg_dst_x      in   COORD_W  destination X coordinate
//  cfg_dst_y      in   COORD_W  destination Y coordinate
//  cfg_pkt_len    in   LEN_W    flits per packet, header included; 0 is treated as 1
//  cfg_num_pkts   in   16       packets in the burst; 0 gives an immediate done with no traffic
//  cfg_gap        in   8        idle cycles inserted between packets
//  sender_valid   out  1        flit valid
//  sender_ready   in   1        router accepts the flit
//  sender_flit    out  DATA_W   flit data
//  sender_is_header out 1       flit is a header flit
//  sender_is_tail out  1        flit is the last flit of the packet
//  busy           out  1        burst in progress
//  done           out  1        1-cycle pulse after the last tail flit is accepted
//  pkts_sent      out  16       packets fully accepted since reset; wraps
// BEHAVIOUR
//  Reset: every output is 0; FSM goes to IDLE; all counters are cleared; latched config is cleared.
//    Reset may assert mid-packet; that packet is abandoned, and no tail is emitted.
//  A transfer happens when sender_valid & sender_ready are high on a rising edge.
//  After sender_valid rises, it stays high, and flit/header/tail stay stable, until the transfer.
//  sender_valid never depends combinationally on sender_ready. All outputs are registered.
//  FSM states:
//   IDLE: wait for cfg_start.
//     cfg_start with cfg_num_pkts==0 -> done pulses the next cycle and the FSM stays in IDLE.
//     Otherwise go to HEAD; busy=1 and valid=1 from the next cycle (start-to-valid latency 1).
//   HEAD: present the header flit.
//     On transfer: if eff_len==1 go to PKT_END, otherwise go to BODY with flit_idx=1.
//   BODY: present payload flit flit_idx, with is_tail=(flit_idx==eff_len-1).
//     On a transfer with tail set go to PKT_END; otherwise increment flit_idx.
//   PKT_END (one cycle, valid=0): pkts_sent++ and seq++.
//     If seq reached num_pkts: go to IDLE, pulse done, set busy=0.
//     Else if gap==0: go to HEAD (two back-to-back packets are separated by exactly 1 idle cycle).
//     Else: go to GAP with gap_cnt=gap.
//   GAP: decrement gap_cnt each cycle; at 1, go to HEAD.
//  Single-flit packet: is_header=1 and is_tail=1 on the same flit.
//  Header flit layout, MSB first: dst_x, dst_y, src_x, src_y, pkt_len(LEN_W), seq (remaining low bits).
//  Body flit: {seq[15:0], flit_idx[15:0]} zero-extended or truncated to DATA_W.
//  Arithmetic: flit_idx is LEN_W wide; seq is 16 bits and wraps; pkts_sent wraps from 0xFFFF to 0.
//  cfg_* inputs are sampled only on an accepted cfg_start. Later changes have no effect until the next burst.
// STRUCTURE
//  Shared package noc_pkg: header field offsets/widths derived from DATA_W/COORD_W/LEN_W, and FSM state encodings.
//  Sub-module noc_flit_builder (combinational): builds the header or body flit from the state fields.
//    Its output is registered in the injector.
//  Main FSM, counters and handshake logic live in noc_traffic_injector.
// TESTING
//  1) Basic burst: len=4, num=2, gap=0, dst=(1,1), ready=1 ->
//     flits H,B1,B2,T; one idle cycle; H,B1,B2,T; done pulses 1 cycle after the 2nd tail; pkts_sent=2.
//  2) Single-flit packets: len=1, num=3, gap=2 ->
//     three flits, each with header=tail=1; seq field 0,1,2; exactly 3 idle cycles between them.
//  3) Backpressure: ready toggles 1,0,0,1,... during len=5 ->
//     flit and flags hold while ready=0; no flit is lost or duplicated; flit_idx fields run 1..4 in order.
//  4) Zero cases: num=0 -> done 1 cycle later, valid never rises; len=0 -> behaves exactly as len=1.
//  5) Reset mid-packet: assert noc_rst during B2 ->
//     all outputs 0 asynchronously; after release the FSM is IDLE and a new start gives seq=0 in the header.
//  6) Start while busy: a second cfg_start with different dst mid-burst ->
//     ignored; all headers keep the original dst.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: FSM encoding and header field geometry shared by the traffic injector and its flit builder.
package noc_pkg;
    typedef enum logic [2:0] {
        IDLE,
        HEAD,
        BODY,
        PKT_END,
        GAP
    } inj_state_e;
    localparam int SEQ_W = 16;
    localparam int BODY_IDX_W = 16;
    function automatic int hdr_fixed_w(input int coord_w, input int len_w);
        return 4 * coord_w + len_w;
    endfunction
    // Whatever is left of the flit below the fixed fields carries the low bits of seq.
    function automatic int hdr_seq_w(input int data_w, input int coord_w, input int len_w);
        return data_w - hdr_fixed_w(coord_w, len_w);
    endfunction
endpackage

// File: rtl/noc_traffic_injector_if.sv
// noc_traffic_injector_if: valid/ready flit channel into one mesh node's router receive port.
interface noc_traffic_injector_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic              is_header;
    logic              is_tail;
    logic [DATA_W-1:0] flit;
    modport master(output valid, flit, is_header, is_tail, input ready);
    modport slave(input valid, flit, is_header, is_tail, output ready);
endinterface

// File: rtl/noc_flit_builder.sv
// noc_flit_builder: combinational header/body flit formatter; the injector registers its output.
module noc_flit_builder
    import noc_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int COORD_W = 4,
    parameter int LEN_W   = 8,
    parameter int SRC_X   = 0,
    parameter int SRC_Y   = 0
) (
    input  logic               header,
    input  logic [COORD_W-1:0] dst_x,
    input  logic [COORD_W-1:0] dst_y,
    input  logic [LEN_W-1:0]   len,
    input  logic [LEN_W-1:0]   idx,
    input  logic [SEQ_W-1:0]   seq,
    output logic [DATA_W-1:0]  flit
);
    localparam int HSEQ_W = hdr_seq_w(DATA_W, COORD_W, LEN_W);
    logic [DATA_W-1:0]           head;
    logic [SEQ_W+BODY_IDX_W-1:0] body;
    assign head = {dst_x, dst_y, COORD_W'(SRC_X), COORD_W'(SRC_Y), len, HSEQ_W'(seq)};
    assign body = {seq, BODY_IDX_W'(idx)};
    assign flit = header ? head : DATA_W'(body);
endmodule

// File: rtl/noc_traffic_injector.sv
// noc_traffic_injector: programmable packet source feeding one node's receive port.
// Every output is registered from next-state values so valid never looks at ready combinationally.
module noc_traffic_injector
    import noc_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int COORD_W = 4,
    parameter int SRC_X   = 0,
    parameter int SRC_Y   = 0,
    parameter int LEN_W   = 8
) (
    input  logic                   noc_clk,
    input  logic                   noc_rst,
    input  logic                   cfg_start,
    input  logic [COORD_W-1:0]     cfg_dst_x,
    input  logic [COORD_W-1:0]     cfg_dst_y,
    input  logic [LEN_W-1:0]       cfg_pkt_len,
    input  logic [15:0]            cfg_num_pkts,
    input  logic [7:0]             cfg_gap,
    noc_traffic_injector_if.master sender,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            pkts_sent
);
    inj_state_e         state, state_n;
    logic [COORD_W-1:0] dst_x, dst_x_n, dst_y, dst_y_n;
    logic [LEN_W-1:0]   len, len_n, idx, idx_n;
    logic [15:0]        num, num_n, seq, seq_n, pkts_n;
    logic [7:0]         gap, gap_n, gap_cnt, gap_cnt_n;
    logic               xfer, last_body, last_pkt, done_n, valid_n, head_n, tail_n;
    logic [DATA_W-1:0]  built;
    assign xfer      = sender.valid & sender.ready;
    assign last_body = idx == len - LEN_W'(1);
    assign last_pkt  = seq + 16'd1 == num;
    always_comb begin
        state_n   = state;
        dst_x_n   = dst_x;
        dst_y_n   = dst_y;
        len_n     = len;
        num_n     = num;
        gap_n     = gap;
        seq_n     = seq;
        idx_n     = idx;
        gap_cnt_n = gap_cnt;
        pkts_n    = pkts_sent;
        done_n    = 1'b0;
        case (state)
            IDLE: if (cfg_start) begin
                dst_x_n = cfg_dst_x;
                dst_y_n = cfg_dst_y;
                len_n   = (cfg_pkt_len == '0) ? LEN_W'(1) : cfg_pkt_len;
                num_n   = cfg_num_pkts;
                gap_n   = cfg_gap;
                seq_n   = '0;
                idx_n   = '0;
                state_n = (cfg_num_pkts == '0) ? IDLE : HEAD;
                done_n  = cfg_num_pkts == '0;
            end
            HEAD: if (xfer) begin
                state_n = (len == LEN_W'(1)) ? PKT_END : BODY;
                idx_n   = LEN_W'(1);
            end
            BODY: if (xfer) begin
                state_n = last_body ? PKT_END : BODY;
                idx_n   = last_body ? idx : idx + LEN_W'(1);
            end
            PKT_END: begin
                pkts_n    = pkts_sent + 16'd1;
                seq_n     = seq + 16'd1;
                gap_cnt_n = gap;
                state_n   = last_pkt ? IDLE : (gap == '0) ? HEAD : GAP;
                done_n    = last_pkt;
            end
            GAP: begin
                gap_cnt_n = gap_cnt - 8'd1;
                state_n   = (gap_cnt == 8'd1) ? HEAD : GAP;
            end
            default: state_n = IDLE;
        endcase
    end
    // Flags and flit are derived from the next state so they land in the same cycle as valid.
    assign valid_n = state_n == HEAD || state_n == BODY;
    assign head_n  = state_n == HEAD;
    assign tail_n  = (state_n == HEAD && len_n == LEN_W'(1)) ||
                     (state_n == BODY && idx_n == len_n - LEN_W'(1));
    noc_flit_builder #(
        .DATA_W (DATA_W),
        .COORD_W(COORD_W),
        .LEN_W  (LEN_W),
        .SRC_X  (SRC_X),
        .SRC_Y  (SRC_Y)
    ) u_builder (
        .header(head_n),
        .dst_x (dst_x_n),
        .dst_y (dst_y_n),
        .len   (len_n),
        .idx   (idx_n),
        .seq   (seq_n),
        .flit  (built)
    );
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            state            <= IDLE;
            dst_x            <= '0;
            dst_y            <= '0;
            len              <= '0;
            num              <= '0;
            gap              <= '0;
            seq              <= '0;
            idx              <= '0;
            gap_cnt          <= '0;
            pkts_sent        <= '0;
            done             <= 1'b0;
            busy             <= 1'b0;
            sender.valid     <= 1'b0;
            sender.is_header <= 1'b0;
            sender.is_tail   <= 1'b0;
            sender.flit      <= '0;
        end else begin
            state            <= state_n;
            dst_x            <= dst_x_n;
            dst_y            <= dst_y_n;
            len              <= len_n;
            num              <= num_n;
            gap              <= gap_n;
            seq              <= seq_n;
            idx              <= idx_n;
            gap_cnt          <= gap_cnt_n;
            pkts_sent        <= pkts_n;
            done             <= done_n;
            busy             <= state_n != IDLE;
            sender.valid     <= valid_n;
            sender.is_header <= head_n;
            sender.is_tail   <= tail_n;
            sender.flit      <= valid_n ? built : '0;
        end
    end
endmodule

// File: tb/tb_noc_traffic_injector.sv
// tb_noc_traffic_injector: directed bursts with randomized backpressure, checked against a flit-list model.
module tb_noc_traffic_injector;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic [3:0]  cfg_dst_x = '0;
    logic [3:0]  cfg_dst_y = '0;
    logic [7:0]  cfg_pkt_len = '0;
    logic [15:0] cfg_num_pkts = '0;
    logic [7:0]  cfg_gap = '0;
    logic        busy, done;
    logic [15:0] pkts_sent;
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] exp_pkts = '0;
    always #5 clk = ~clk;
    noc_traffic_injector_if #(.DATA_W(32)) snd ();
    noc_traffic_injector #(
        .DATA_W (32),
        .COORD_W(4),
        .SRC_X  (3),
        .SRC_Y  (5),
        .LEN_W  (8)
    ) dut (
        .noc_clk     (clk),
        .noc_rst     (rst),
        .cfg_start   (cfg_start),
        .cfg_dst_x   (cfg_dst_x),
        .cfg_dst_y   (cfg_dst_y),
        .cfg_pkt_len (cfg_pkt_len),
        .cfg_num_pkts(cfg_num_pkts),
        .cfg_gap     (cfg_gap),
        .sender      (snd),
        .busy        (busy),
        .done        (done),
        .pkts_sent   (pkts_sent)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    // Header: dst_x, dst_y, src_x=3, src_y=5, length, low 8 bits of the packet sequence number.
    function automatic logic [31:0] hdr(input logic [3:0] dx, input logic [3:0] dy, input int len, input int seq);
        return {dx, dy, 4'd3, 4'd5, 8'(len), 8'(seq)};
    endfunction
    function automatic logic [31:0] bdy(input int seq, input int idx);
        return {16'(seq), 16'(idx)};
    endfunction
    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, 32'(snd.valid), 0);
        chk({tag, "_flit"}, snd.flit, 0);
        chk({tag, "_hdr"}, 32'(snd.is_header), 0);
        chk({tag, "_tail"}, 32'(snd.is_tail), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask
    // rmode: 0 ready always high, 1 pattern 1,0,0 repeating, 2 random.
    task automatic run_burst(input logic [3:0] dx, input logic [3:0] dy, input logic [7:0] len,
                             input logic [15:0] num, input logic [7:0] gap, input int rmode, input bit poke);
        logic [31:0] eq[$];
        bit          eh[$];
        bit          et[$];
        int          eff, cyc, ptr, last_tail, rp;
        bit          stall, r;
        logic [31:0] pf;
        eff = (len == 0) ? 1 : int'(len);
        for (int p = 0; p < int'(num); p++)
            for (int i = 0; i < eff; i++) begin
                eq.push_back(i == 0 ? hdr(dx, dy, eff, p) : bdy(p, i));
                eh.push_back(i == 0);
                et.push_back(i == eff - 1);
            end
        cyc = 0; ptr = 0; last_tail = -1; rp = 0; stall = 1'b0; pf = '0;
        @(negedge clk);
        cfg_dst_x = dx; cfg_dst_y = dy; cfg_pkt_len = len; cfg_num_pkts = num; cfg_gap = gap;
        cfg_start = 1'b1;
        snd.ready = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_dst_x = ~dx; cfg_dst_y = ~dy; cfg_pkt_len = 8'hFF; cfg_num_pkts = 16'hFFFF; cfg_gap = 8'd9;
        if (num == 0) begin
            chk("zero_done", 32'(done), 1);
            chk("zero_valid", 32'(snd.valid), 0);
            chk("zero_busy", 32'(busy), 0);
            @(negedge clk);
            chk_quiet("zero_after");
            return;
        end
        while (ptr < eq.size() && cyc < 4000) begin
            chk("busy", 32'(busy), 1);
            chk("done_low", 32'(done), 0);
            if (stall) begin
                chk("hold_valid", 32'(snd.valid), 1);
                chk("hold_flit", snd.flit, pf);
            end
            if (snd.valid) begin
                chk("flit", snd.flit, eq[ptr]);
                chk("is_header", 32'(snd.is_header), 32'(eh[ptr]));
                chk("is_tail", 32'(snd.is_tail), 32'(et[ptr]));
                if (eh[ptr] && !stall) chk("head_time", cyc, ptr == 0 ? 0 : last_tail + 2 + int'(gap));
            end
            if (poke) begin
                cfg_start = cyc == 3;
                cfg_dst_x = cfg_start ? dx + 4'd1 : ~dx;
                cfg_num_pkts = cfg_start ? 16'd7 : 16'hFFFF;
            end
            r = rmode == 0 ? 1'b1 : rmode == 1 ? (rp % 3 == 0) : 1'($urandom_range(0, 1));
            rp++;
            snd.ready = r;
            if (snd.valid && r) begin
                if (et[ptr]) last_tail = cyc;
                ptr++;
            end
            stall = snd.valid && !r;
            pf = snd.flit;
            @(negedge clk);
            cyc++;
        end
        cfg_start = 1'b0;
        chk("all_flits", ptr, eq.size());
        chk("pktend_valid", 32'(snd.valid), 0);
        chk("pktend_done", 32'(done), 0);
        @(negedge clk);
        exp_pkts = exp_pkts + num;
        chk("done", 32'(done), 1);
        chk("busy_end", 32'(busy), 0);
        chk("pkts_sent", 32'(pkts_sent), 32'(exp_pkts));
        @(negedge clk);
        chk_quiet("after_done");
        chk("pkts_hold", 32'(pkts_sent), 32'(exp_pkts));
    endtask
    initial begin
        snd.ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_quiet("reset");
        chk("reset_pkts", 32'(pkts_sent), 0);
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("idle");
        run_burst(4'd1, 4'd1, 8'd4, 16'd2, 8'd0, 0, 1'b0);
        run_burst(4'd2, 4'd3, 8'd1, 16'd3, 8'd2, 0, 1'b0);
        run_burst(4'd4, 4'd5, 8'd5, 16'd2, 8'd1, 1, 1'b0);
        run_burst(4'd6, 4'd7, 8'd3, 16'd0, 8'd0, 0, 1'b0);
        run_burst(4'd6, 4'd7, 8'd0, 16'd2, 8'd0, 2, 1'b0);
        run_burst(4'd8, 4'd9, 8'd3, 16'd3, 8'd1, 0, 1'b1);
        // Abandon a packet during its second body flit.
        @(negedge clk);
        cfg_dst_x = 4'd12; cfg_dst_y = 4'd13; cfg_pkt_len = 8'd6; cfg_num_pkts = 16'd2; cfg_gap = 8'd0;
        cfg_start = 1'b1;
        snd.ready = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("b2_before_rst", snd.flit, bdy(0, 2));
        #2 rst = 1'b1;
        #1 chk_quiet("async_rst");
        chk("rst_pkts", 32'(pkts_sent), 0);
        @(negedge clk);
        rst = 1'b0;
        exp_pkts = '0;
        @(negedge clk);
        chk_quiet("post_rst");
        run_burst(4'd10, 4'd11, 8'd3, 16'd1, 8'd0, 0, 1'b0);
        for (int k = 0; k < 4; k++)
            run_burst(4'($urandom), 4'($urandom), 8'($urandom_range(0, 6)), 16'($urandom_range(1, 3)),
                      8'($urandom_range(0, 3)), 2, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
